// File: rtl/line_memory_pkg.sv
// Shared types and width helpers for the line-granular multi-port memory.
package line_memory_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } port_state_t;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/line_memory_port.sv
// One request port: accepts a line request when idle, counts down the fixed
// latency and flags the edge at which the top level must perform the operation.
module line_memory_port
    import line_memory_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           req_valid,
    input  logic                           req_write,
    input  logic [ADDR_W-1:0]              req_addr,
    input  logic [LINE_WORDS*WORD_W-1:0]   req_wdata,
    input  logic [LINE_WORDS-1:0]          req_wmask,
    output logic                           req_ready,
    output logic                           rsp_valid,
    output logic                           exec,
    output logic                           op_write,
    output logic [idx_w(DEPTH)-1:0]        op_idx,
    output logic [LINE_WORDS*WORD_W-1:0]   op_wdata,
    output logic [LINE_WORDS-1:0]          op_wmask
);

    localparam int unsigned OFF_W = off_w(LINE_WORDS);
    localparam int unsigned IDX_W = idx_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(LATENCY);
    localparam logic [IDX_W-1:0] ALIGN_MASK = ~IDX_W'((1 << OFF_W) - 1);

    port_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             unused_addr;

    // Address bits above the array index are ignored (wrap-around).
    assign unused_addr = ^req_addr;
    assign exec        = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            op_write  <= 1'b0;
            op_idx    <= '0;
            op_wdata  <= '0;
            op_wmask  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= BUSY;
                        req_ready <= 1'b0;
                        cnt       <= CNT_W'(LATENCY - 1);
                        op_write  <= req_write;
                        op_idx    <= req_addr[IDX_W-1:0] & ALIGN_MASK;
                        op_wdata  <= req_wdata;
                        op_wmask  <= req_wmask;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/line_memory.sv
// Multi-port line memory with fixed latency; optional per-word write mask
// enabled by defining LINE_MEMORY_WMASK_EN.
module line_memory
    import line_memory_pkg::*;
#(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_PORTS-1:0]                   req_valid,
    output logic [NUM_PORTS-1:0]                   req_ready,
    input  logic [NUM_PORTS-1:0]                   req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]            req_addr,
    input  logic [NUM_PORTS*LINE_WORDS*WORD_W-1:0] req_wdata,
`ifdef LINE_MEMORY_WMASK_EN
    input  logic [NUM_PORTS*LINE_WORDS-1:0]        req_wmask,
`endif
    output logic [NUM_PORTS-1:0]                   rsp_valid,
    output logic [NUM_PORTS*LINE_WORDS*WORD_W-1:0] rsp_rdata
);

    localparam int unsigned IDX_W  = idx_w(DEPTH);
    localparam int unsigned LINE_W = LINE_WORDS * WORD_W;

    logic [WORD_W-1:0]             mem [DEPTH];
    logic [NUM_PORTS-1:0]          exec;
    logic [NUM_PORTS-1:0]          op_write;
    logic [IDX_W-1:0]              op_idx   [NUM_PORTS];
    logic [LINE_W-1:0]             op_wdata [NUM_PORTS];
    logic [LINE_WORDS-1:0]         op_wmask [NUM_PORTS];
    logic [NUM_PORTS*LINE_WORDS-1:0] wmask;

`ifdef LINE_MEMORY_WMASK_EN
    assign wmask = req_wmask;
`else
    assign wmask = '1;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        line_memory_port #(
            .WORD_W     (WORD_W),
            .ADDR_W     (ADDR_W),
            .DEPTH      (DEPTH),
            .LINE_WORDS (LINE_WORDS),
            .LATENCY    (LATENCY)
        ) u_port (
            .clk       (clk),
            .reset_n   (reset_n),
            .req_valid (req_valid[p]),
            .req_write (req_write[p]),
            .req_addr  (req_addr[p*ADDR_W +: ADDR_W]),
            .req_wdata (req_wdata[p*LINE_W +: LINE_W]),
            .req_wmask (wmask[p*LINE_WORDS +: LINE_WORDS]),
            .req_ready (req_ready[p]),
            .rsp_valid (rsp_valid[p]),
            .exec      (exec[p]),
            .op_write  (op_write[p]),
            .op_idx    (op_idx[p]),
            .op_wdata  (op_wdata[p]),
            .op_wmask  (op_wmask[p])
        );
    end

    // Highest port is applied first so the lowest port's assignment lands last
    // and wins on any word written by several ports at the same edge.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            for (int unsigned i = 0; i < LINE_WORDS; i++) begin
                if (exec[NUM_PORTS-1-k] && op_write[NUM_PORTS-1-k] && op_wmask[NUM_PORTS-1-k][i])
                    mem[op_idx[NUM_PORTS-1-k] + IDX_W'(i)] <= op_wdata[NUM_PORTS-1-k][i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (exec[p] && !op_write[p]) begin
                    for (int unsigned i = 0; i < LINE_WORDS; i++)
                        rsp_rdata[(p*LINE_WORDS+i)*WORD_W +: WORD_W] <= mem[op_idx[p] + IDX_W'(i)];
                end
            end
        end
    end

endmodule

// File: tb/tb_line_memory.sv
// Self-checking bench for line_memory: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_line_memory;

    localparam int WORD_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int DEPTH      = 512;
    localparam int LINE_WORDS = 4;
    localparam int NUM_PORTS  = 2;
    localparam int LATENCY    = 4;
    localparam int LINE_W     = WORD_W * LINE_WORDS;

    logic                            clk = 1'b0;
    logic                            reset_n;
    logic [NUM_PORTS-1:0]            req_valid, req_ready, req_write, rsp_valid;
    logic [NUM_PORTS*ADDR_W-1:0]     req_addr;
    logic [NUM_PORTS*LINE_W-1:0]     req_wdata, rsp_rdata;
    logic [NUM_PORTS*LINE_WORDS-1:0] req_wmask;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    line_memory #(
        .WORD_W     (WORD_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .LINE_WORDS (LINE_WORDS),
        .NUM_PORTS  (NUM_PORTS),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef LINE_MEMORY_WMASK_EN
        .req_wmask (req_wmask),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural model: word array plus per-port pending transaction with
    // an absolute completion time.
    logic [WORD_W-1:0]     ref_mem [DEPTH];
    bit                    pend    [NUM_PORTS];
    int                    done_at [NUM_PORTS];
    bit                    op_wr   [NUM_PORTS];
    int                    op_base [NUM_PORTS];
    logic [LINE_W-1:0]     op_data [NUM_PORTS];
    logic [LINE_WORDS-1:0] op_mask [NUM_PORTS];
    bit                    exp_rsp [NUM_PORTS];
    logic [LINE_W-1:0]     exp_rd  [NUM_PORTS];

    function automatic void check(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < NUM_PORTS; p++) begin
            pend[p] = 0; exp_rsp[p] = 0; exp_rd[p] = '0;
        end
    endfunction

    function automatic void model_edge();
        bit was_busy [NUM_PORTS];
        bit done     [NUM_PORTS];
        bit taken    [int];
        for (int p = 0; p < NUM_PORTS; p++) begin
            was_busy[p] = pend[p]; exp_rsp[p] = 0; done[p] = 0;
        end
        if (!reset_n) return;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pend[p] && done_at[p] == cyc) begin
                done[p] = 1; exp_rsp[p] = 1; pend[p] = 0;
                if (!op_wr[p])
                    for (int i = 0; i < LINE_WORDS; i++)
                        exp_rd[p][i*WORD_W +: WORD_W] = ref_mem[op_base[p] + i];
            end
        end
        // Lowest port claims each address first; later ports skip claimed words.
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (done[p] && op_wr[p])
                for (int i = 0; i < LINE_WORDS; i++)
                    if (op_mask[p][i] && !taken.exists(op_base[p] + i)) begin
                        taken[op_base[p] + i] = 1;
                        ref_mem[op_base[p] + i] = op_data[p][i*WORD_W +: WORD_W];
                    end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!was_busy[p] && req_valid[p]) begin
                int a;
                a = int'(req_addr[p*ADDR_W +: ADDR_W]) % DEPTH;
                pend[p]    = 1;
                done_at[p] = cyc + LATENCY;
                op_wr[p]   = req_write[p];
                op_base[p] = a - (a % LINE_WORDS);
                op_data[p] = req_wdata[p*LINE_W +: LINE_W];
`ifdef LINE_MEMORY_WMASK_EN
                op_mask[p] = req_wmask[p*LINE_WORDS +: LINE_WORDS];
`else
                op_mask[p] = '1;
`endif
            end
        end
    endfunction

    function automatic void check_outputs();
        for (int p = 0; p < NUM_PORTS; p++) begin
            check($sformatf("req_ready[%0d]", p), LINE_W'(req_ready[p]), LINE_W'(!pend[p]));
            check($sformatf("rsp_valid[%0d]", p), LINE_W'(rsp_valid[p]), LINE_W'(exp_rsp[p]));
            check($sformatf("rsp_rdata[%0d]", p), rsp_rdata[p*LINE_W +: LINE_W], exp_rd[p]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_req(input int p, input bit wr, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] data, input logic [LINE_WORDS-1:0] mask);
        req_valid[p] = 1'b1;
        req_write[p] = wr;
        req_addr[p*ADDR_W +: ADDR_W]          = addr;
        req_wdata[p*LINE_W +: LINE_W]         = data;
        req_wmask[p*LINE_WORDS +: LINE_WORDS] = mask;
    endtask

    task automatic do_op(input int p, input bit wr, input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] data, input logic [LINE_WORDS-1:0] mask,
                         output logic [LINE_W-1:0] rd);
        int n = 0;
        while (!req_ready[p] && n < 50) begin tick(); n++; end
        check("ready_wait", LINE_W'(req_ready[p]), LINE_W'(1));
        set_req(p, wr, addr, data, mask);
        tick();
        req_valid[p] = 1'b0;
        n = 0;
        while (!rsp_valid[p] && n < 50) begin tick(); n++; end
        check("latency", LINE_W'(n), LINE_W'(LATENCY));
        rd = rsp_rdata[p*LINE_W +: LINE_W];
    endtask

    task automatic pair(input bit w0, input logic [ADDR_W-1:0] a0, input logic [LINE_W-1:0] d0,
                        input bit w1, input logic [ADDR_W-1:0] a1, input logic [LINE_W-1:0] d1,
                        output logic [LINE_W-1:0] r0, output logic [LINE_W-1:0] r1);
        int n = 0;
        set_req(0, w0, a0, d0, '1);
        set_req(1, w1, a1, d1, '1);
        tick();
        req_valid = '0;
        while (!(rsp_valid[0] && rsp_valid[1]) && n < 50) begin tick(); n++; end
        check("pair_latency", LINE_W'(n), LINE_W'(LATENCY));
        r0 = rsp_rdata[0 +: LINE_W];
        r1 = rsp_rdata[LINE_W +: LINE_W];
    endtask

    typedef struct {
        int                port;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] data;
        logic [LINE_W-1:0] exp;
        bit                chk;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [LINE_W-1:0] rd, r0, r1;

        vecs[0] = '{0, 1, 16'h0000, 64'h0000_FFFF_0001_9023, 64'h0, 0};
        vecs[1] = '{0, 0, 16'h0000, 64'h0, 64'h0000_FFFF_0001_9023, 1};
        vecs[2] = '{1, 1, 16'h0043, 64'h4444_3333_2222_1111, 64'h0, 0};
        vecs[3] = '{1, 0, 16'h0040, 64'h0, 64'h4444_3333_2222_1111, 1};
        vecs[4] = '{0, 0, 16'h0042, 64'h0, 64'h4444_3333_2222_1111, 1};
        vecs[5] = '{0, 1, 16'h0004, 64'h7777_6666_5555_4444, 64'h0, 0};
        vecs[6] = '{1, 0, 16'h0204, 64'h0, 64'h7777_6666_5555_4444, 1};
        vecs[7] = '{1, 1, 16'hFFFD, 64'h0BAD_0BAD_0BAD_0BAD, 64'h0, 0};
        vecs[8] = '{0, 0, 16'h01FC, 64'h0, 64'h0BAD_0BAD_0BAD_0BAD, 1};

        reset_n   = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wmask = '1;
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        reset_n = 1'b1;
        tick();

        // Give every line a known value so the model never holds unknowns.
        for (int l = 0; l < DEPTH / LINE_WORDS / 2; l++)
            pair(1, ADDR_W'(l * LINE_WORDS), '0, 1, ADDR_W'((l + DEPTH / LINE_WORDS / 2) * LINE_WORDS), '0, r0, r1);

        foreach (vecs[v]) begin
            do_op(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].data, '1, rd);
            if (vecs[v].chk) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
        end

        // Read and write of the same line at the same edge.
        do_op(0, 1, 16'h0010, 64'h1010_1010_1010_1010, '1, rd);
        pair(0, 16'h0010, '0, 1, 16'h0011, 64'h5A5A_A5A5_5A5A_A5A5, r0, r1);
        check("rw_same_line_old", r0, 64'h1010_1010_1010_1010);
        do_op(1, 0, 16'h0010, '0, '1, rd);
        check("rw_same_line_new", rd, 64'h5A5A_A5A5_5A5A_A5A5);

        // Two writes to the same line: port 0 wins.
        pair(1, 16'h0020, 64'hAAAA_AAAA_AAAA_AAAA, 1, 16'h0022, 64'hBBBB_BBBB_BBBB_BBBB, r0, r1);
        do_op(1, 0, 16'h0020, '0, '1, rd);
        check("ww_priority", rd, 64'hAAAA_AAAA_AAAA_AAAA);

        // Reset two cycles into a write abandons it.
        do_op(0, 1, 16'h0030, 64'h0123_4567_89AB_CDEF, '1, rd);
        set_req(0, 1, 16'h0030, 64'hFFFF_FFFF_FFFF_FFFF, '1);
        tick();
        req_valid = '0;
        tick(); tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < LATENCY + 3; i++) tick();
        do_op(0, 0, 16'h0030, '0, '1, rd);
        check("reset_abandon", rd, 64'h0123_4567_89AB_CDEF);

`ifdef LINE_MEMORY_WMASK_EN
        do_op(0, 1, 16'h0050, '0, 4'b1111, rd);
        do_op(0, 1, 16'h0050, 64'hDDDD_CCCC_BBBB_AAAA, 4'b0101, rd);
        do_op(1, 1, 16'h0050, 64'h9999_9999_9999_9999, 4'b0000, rd);
        do_op(1, 0, 16'h0050, '0, 4'b0000, rd);
        check("wmask_0101", rd, 64'h0000_CCCC_0000_AAAA);
`endif

        // Randomized traffic on a few colliding lines, including aliases above DEPTH.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ($urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)),
                            ADDR_W'($urandom_range(0, 3) * 512 + 16'h60 + $urandom_range(0, 11)),
                            {$urandom, $urandom}, LINE_WORDS'($urandom));
                else
                    req_valid[p] = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        for (int i = 0; i < LATENCY + 3; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_memory.md
Name: line_memory

Overview:
- Parametrised multi-port, line-granular memory model. It is the successor to the fixed two-port (I/D) 4-word fetch memory.
- Each of NUM_PORTS independent ports issues line reads or writes through a valid/ready request and a response pulse.
- Latency is a fixed, configurable number of cycles.
- Sits below the I-cache, D-cache and DMA engine, and replaces the inout-bus memory. Read and write data buses are separate.

Parameters:
- WORD_W, 16, bits per word
- ADDR_W, 16, word-address width per port
- DEPTH, 512, words in the array; power of two, multiple of LINE_WORDS
- LINE_WORDS, 4, words per line; power of two, 1 or more
- NUM_PORTS, 2, independent request ports; 1 or more
- LATENCY, 4, cycles from request acceptance to completion; 1 or more

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  per-port request valid
- req_ready  out  NUM_PORTS  per-port ready; 1 when the port is idle
- req_write  in  NUM_PORTS  1 = line write, 0 = line read
- req_addr  in  NUM_PORTS*ADDR_W  word addresses, port p at [p*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_PORTS*LINE_WORDS*WORD_W  write line; word i at the lowest slice offset i
- rsp_valid  out  NUM_PORTS  one-cycle completion pulse, for both reads and writes
- rsp_rdata  out  NUM_PORTS*LINE_WORDS*WORD_W  read line, same word ordering as req_wdata

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: req_ready=all 1, rsp_valid=0, rsp_rdata=0, all port FSMs IDLE, counters 0.
- Array contents are not reset. They survive reset_n assertion.
- Per-port FSM states: IDLE, BUSY.
  - IDLE: req_ready=1. On req_valid=1, latch write flag, aligned address and wdata. Load cnt=LATENCY-1 and go to BUSY.
  - BUSY: req_ready=0. Inputs are ignored. cnt decrements each cycle. When cnt==0, perform the operation at that edge and return to IDLE.
- Timing: for a request accepted at edge t, the operation executes at edge t+LATENCY.
  - rsp_valid=1 for exactly the cycle after t+LATENCY.
  - req_ready is 1 again in that same cycle, so back-to-back throughput is one operation per LATENCY cycles.
- Address rules:
  - Line base = req_addr with the low log2(LINE_WORDS) bits cleared.
  - Array index = base modulo DEPTH; upper address bits are ignored (wrap-around).
  - Word i of the line is array[base+i]. A line never straddles the DEPTH boundary.
- Read: rsp_rdata is loaded at the execute edge and holds until that port's next read completes. It is never high-Z.
- Write: the array updates at the execute edge. rsp_valid pulses and rsp_rdata is unchanged.
- Simultaneous execute on the same line:
  - Read versus write: the read returns the pre-write data.
  - Write versus write: the lowest-index port's data wins.
- Ports never stall one another. There is no arbitration beyond the same-line write priority.
- Reset mid-operation: any BUSY operation is abandoned. No array write occurs and no rsp_valid is produced.

Optional Feature:
- Macro: LINE_MEMORY_WMASK_EN.
- Defined: adds input req_wmask (NUM_PORTS*LINE_WORDS bits), latched at acceptance.
  - Word i is written only if its mask bit is 1. Unmasked words are unchanged.
  - A mask of all zeros still completes with an rsp_valid pulse.
  - Write-versus-write priority on the same line is resolved per word among enabled words.
- Undefined: no port exists. Every write stores all LINE_WORDS words.

Decomposition:
- Package line_memory_pkg holds:
  - port state enum (IDLE, BUSY)
  - localparam helper functions for OFF_W=$clog2(LINE_WORDS), IDX_W=$clog2(DEPTH) and CNT_W=$clog2(LATENCY+1)
- Sub-module line_memory_port: per-port FSM, latency counter and request latch, instantiated NUM_PORTS times with a generate loop.
- The array, the write-priority resolution and the read muxing stay in the top level.

Test Plan:
- Reset, then port0 reads addr 0x0000 (array preloaded with 0x9023, 0x0001, 0xFFFF, 0x0000) -> rsp_valid rises 4 cycles after acceptance, rsp_rdata=0x0000_FFFF_0001_9023, req_ready low for exactly 4 cycles.
- Port1 writes addr 0x0043 with 0x4444_3333_2222_1111, then reads 0x0040 -> the write is stored at 0x40–0x43 and the read returns 0x4444_3333_2222_1111.
- Port0 reads and port1 writes line 0x10 in the same cycle -> port0 returns the old data; a later read returns the new data.
- Both ports write line 0x20 in the same cycle with 0xAAAA... and 0xBBBB... -> the array holds 0xAAAA... (port0 wins).
- Read at addr 0x0204 with DEPTH=512 -> returns the contents of 0x0004–0x0007 (wrap-around). Assert reset_n two cycles into a write -> no rsp_valid, target line unchanged.
- LINE_MEMORY_WMASK_EN defined, mask 4'b0101 writing 0xDDDD_CCCC_BBBB_AAAA over zeros -> line reads 0x0000_CCCC_0000_AAAA.
